// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code link: step classification codes and
// decoder FSM state encodings. Used by the decoder, its interface and any
// checker that needs to interpret the Step output.
package gray_pkg;

  typedef logic [1:0] step_t;

  localparam step_t STEP_HOLD = 2'b00;
  localparam step_t STEP_UP   = 2'b01;
  localparam step_t STEP_DOWN = 2'b10;
  localparam step_t STEP_ILL  = 2'b11;

  typedef enum logic [1:0] {
    S_EMPTY = 2'b00,
    S_TRACK = 2'b01,
    S_ERR   = 2'b10
  } state_e;

endpackage

// File: rtl/gray_decoder_if.sv
// Bus between a Gray-code source and the gray_decoder.
//   master : drives En, Gray_in, Resync; observes the decoder outputs
//   slave  : the decoder side
// Signals:
//   En        sample Gray_in at this rising edge
//   Gray_in   WIDTH-bit Gray code
//   Resync    drop ERR and treat the next sample as the first one
//   Bin_out   binary value of the last accepted code
//   Out_valid one-cycle pulse after each accepted sample
//   Step      hold / up / down / illegal for the last accepted sample
//   Overflow, Underflow, Error  sticky flags
//   Wrap_cnt  saturating count of overflow plus underflow events
interface gray_decoder_if
  import gray_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int CNT_W = 4
);
  logic             En;
  logic [WIDTH-1:0] Gray_in;
  logic             Resync;
  logic [WIDTH-1:0] Bin_out;
  logic             Out_valid;
  step_t            Step;
  logic             Overflow;
  logic             Underflow;
  logic             Error;
  logic [CNT_W-1:0] Wrap_cnt;

  modport master (
    output En, Gray_in, Resync,
    input  Bin_out, Out_valid, Step, Overflow, Underflow, Error, Wrap_cnt
  );

  modport slave (
    input  En, Gray_in, Resync,
    output Bin_out, Out_valid, Step, Overflow, Underflow, Error, Wrap_cnt
  );
endinterface

// File: rtl/gray2bin.sv
// Purely combinational Gray-to-binary converter.
//   gray : WIDTH-bit Gray code in
//   bin  : WIDTH-bit binary out, bin[i] = XOR of gray[WIDTH-1:i]
module gray2bin #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Each binary bit is the parity of the Gray bits at and above it.
  always_comb begin
    bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/gray_decoder.sv
// Receiving end of the Gray-code counter link. Converts each sampled Gray code
// to binary, classifies the step against the previous accepted value, tracks
// wrap-around with sticky Overflow/Underflow flags and a saturating wrap
// counter, and latches a sticky Error on any multi-bit jump until Resync.
// Ports:
//   Clk   rising-edge clock
//   Reset asynchronous active-high reset, clears all state
//   bus   gray_decoder_if slave side (En, Gray_in, Resync in; results out)
module gray_decoder
  import gray_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int CNT_W = 4
) (
  input  logic           Clk,
  input  logic           Reset,
  gray_decoder_if.slave  bus
);

  function automatic step_t classify(input logic [WIDTH-1:0] d);
    if (d == '0)                 return STEP_HOLD;
    else if (d == WIDTH'(1))     return STEP_UP;
    else if (d == {WIDTH{1'b1}}) return STEP_DOWN;
    else                         return STEP_ILL;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  state_e           state_p1, state_nxt;
  logic [WIDTH-1:0] bin_p1,   bin_nxt;
  logic             vld_p1,   vld_nxt;
  step_t            step_p1,  step_nxt;
  logic             ovf_p1,   ovf_nxt;
  logic             unf_p1,   unf_nxt;
  logic             err_p1,   err_nxt;
  logic [CNT_W-1:0] wrap_p1,  wrap_nxt;

  logic [WIDTH-1:0] b_p0;
  logic [WIDTH-1:0] d_p0;
  step_t            cls_p0;

  // ---- stage p0: decode and classify the incoming sample ----
  gray2bin #(.WIDTH(WIDTH)) u_gray2bin (
    .gray (bus.Gray_in),
    .bin  (b_p0)
  );

  // Modular difference: wrap-around steps show up as +1 / all-ones.
  assign d_p0   = b_p0 - bin_p1;
  assign cls_p0 = classify(d_p0);

  // Next state. Resync dominates En.
  always_comb begin
    state_nxt = state_p1;
    if (bus.Resync) begin
      state_nxt = S_EMPTY;
    end else if (bus.En) begin
      unique case (state_p1)
        S_EMPTY: state_nxt = S_TRACK;
        S_TRACK: state_nxt = (cls_p0 == STEP_ILL) ? S_ERR : S_TRACK;
        default: state_nxt = S_ERR;
      endcase
    end
  end

  // Next values of the registered outputs.
  always_comb begin
    bin_nxt  = bin_p1;
    vld_nxt  = 1'b0;
    step_nxt = step_p1;
    ovf_nxt  = ovf_p1;
    unf_nxt  = unf_p1;
    err_nxt  = err_p1;
    wrap_nxt = wrap_p1;
    if (bus.Resync) begin
      // Sample (if any) is dropped; wrap history is preserved.
      err_nxt = 1'b0;
    end else if (bus.En) begin
      bin_nxt = b_p0;
      vld_nxt = 1'b1;
      unique case (state_p1)
        S_EMPTY: step_nxt = STEP_HOLD;
        S_TRACK: begin
          step_nxt = cls_p0;
          if (cls_p0 == STEP_UP && bin_p1 == {WIDTH{1'b1}}) begin
            ovf_nxt  = 1'b1;
            wrap_nxt = sat_inc(wrap_p1);
          end
          if (cls_p0 == STEP_DOWN && bin_p1 == '0) begin
            unf_nxt  = 1'b1;
            wrap_nxt = sat_inc(wrap_p1);
          end
          if (cls_p0 == STEP_ILL) begin
            err_nxt = 1'b1;
          end
        end
        default: step_nxt = STEP_ILL;
      endcase
    end
  end

  // ---- stage p1: registered state and outputs ----
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_p1 <= S_EMPTY;
      bin_p1   <= '0;
      vld_p1   <= 1'b0;
      step_p1  <= STEP_HOLD;
      ovf_p1   <= 1'b0;
      unf_p1   <= 1'b0;
      err_p1   <= 1'b0;
      wrap_p1  <= '0;
    end else begin
      state_p1 <= state_nxt;
      bin_p1   <= bin_nxt;
      vld_p1   <= vld_nxt;
      step_p1  <= step_nxt;
      ovf_p1   <= ovf_nxt;
      unf_p1   <= unf_nxt;
      err_p1   <= err_nxt;
      wrap_p1  <= wrap_nxt;
    end
  end

  assign bus.Bin_out   = bin_p1;
  assign bus.Out_valid = vld_p1;
  assign bus.Step      = step_p1;
  assign bus.Overflow  = ovf_p1;
  assign bus.Underflow = unf_p1;
  assign bus.Error     = err_p1;
  assign bus.Wrap_cnt  = wrap_p1;

endmodule

// File: tb/tb_gray_decoder.sv
// Self-checking bench for gray_decoder (WIDTH=3, CNT_W=2). A behavioural model
// tracks the expected outputs; a compare process checks every cycle, and
// directed sequences pin literal values.
module tb_gray_decoder;
  localparam int WIDTH = 3;
  localparam int CNT_W = 2;
  localparam int N     = 1 << WIDTH;
  localparam int WMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  gray_decoder_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  gray_decoder #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int to_gray(input int n);
    return n ^ (n >> 1);
  endfunction

  // Inverse by table search: find the value whose Gray code matches.
  function automatic int from_gray(input int g);
    int r;
    r = -1;
    for (int n = 0; n < N; n++) if (to_gray(n) == g) r = n;
    return r;
  endfunction

  int m_bin, m_vld, m_step, m_ovf, m_unf, m_err, m_wrap, m_first;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_bin <= 0; m_vld <= 0; m_step <= 0; m_ovf <= 0; m_unf <= 0;
      m_err <= 0; m_wrap <= 0; m_first <= 1;
    end else if (bus.Resync) begin
      m_first <= 1; m_err <= 0; m_vld <= 0;
    end else if (!bus.En) begin
      m_vld <= 0;
    end else begin
      m_vld   <= 1;
      m_bin   <= from_gray(int'(bus.Gray_in));
      m_first <= 0;
      if (m_first != 0) m_step <= 0;
      else if (m_err != 0) m_step <= 3;
      else begin
        case ((from_gray(int'(bus.Gray_in)) - m_bin + N) % N)
          0: m_step <= 0;
          1: begin
            m_step <= 1;
            if (m_bin == N - 1) begin
              m_ovf  <= 1;
              m_wrap <= (m_wrap < WMAX) ? m_wrap + 1 : m_wrap;
            end
          end
          N - 1: begin
            m_step <= 2;
            if (m_bin == 0) begin
              m_unf  <= 1;
              m_wrap <= (m_wrap < WMAX) ? m_wrap + 1 : m_wrap;
            end
          end
          default: begin
            m_step <= 3;
            m_err  <= 1;
          end
        endcase
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input int exp);
    n_checks++;
    if (act !== 32'(exp)) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic check_model();
    chk("bin",  32'(bus.Bin_out),   m_bin);
    chk("vld",  32'(bus.Out_valid), m_vld);
    chk("step", 32'(bus.Step),      m_step);
    chk("ovf",  32'(bus.Overflow),  m_ovf);
    chk("unf",  32'(bus.Underflow), m_unf);
    chk("err",  32'(bus.Error),     m_err);
    chk("wrap", 32'(bus.Wrap_cnt),  m_wrap);
  endtask

  always @(negedge clk) check_model();

  // Literal expectations for all outputs.
  task automatic expect_all(input string tag, input int bin, input int vld, input int step,
                            input int ovf, input int unf, input int err, input int wrap);
    chk({tag, ".bin"},  32'(bus.Bin_out),   bin);
    chk({tag, ".vld"},  32'(bus.Out_valid), vld);
    chk({tag, ".step"}, 32'(bus.Step),      step);
    chk({tag, ".ovf"},  32'(bus.Overflow),  ovf);
    chk({tag, ".unf"},  32'(bus.Underflow), unf);
    chk({tag, ".err"},  32'(bus.Error),     err);
    chk({tag, ".wrap"}, 32'(bus.Wrap_cnt),  wrap);
  endtask

  // ---------------- stimulus ----------------
  task automatic drive(input int g, input bit en, input bit rs);
    @(negedge clk);
    bus.Gray_in = WIDTH'(g);
    bus.En      = en;
    bus.Resync  = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.En = 1'b0; bus.Resync = 1'b0;
    #2 rst = 1'b1;
    #1 rst = 1'b0;
  endtask

  task automatic up_cycle();
    for (int i = 1; i <= N; i++) drive(to_gray(i % N), 1'b1, 1'b0);
  endtask

  int cur;

  initial begin
    bus.En = 1'b0; bus.Resync = 1'b0; bus.Gray_in = '0;
    #1 rst = 1'b1;
    #12 rst = 1'b0;
    #1 expect_all("reset", 0, 0, 0, 0, 0, 0, 0);

    // Full up cycle: 000,001,011,010,110,111,101,100,000
    begin
      int gseq[9] = '{0, 1, 3, 2, 6, 7, 5, 4, 0};
      for (int i = 0; i < 9; i++) begin
        drive(gseq[i], 1'b1, 1'b0);
        expect_all("up", i % 8, 1, (i == 0) ? 0 : 1, (i == 8) ? 1 : 0, 0, 0, (i == 8) ? 1 : 0);
      end
    end

    // Down cycle from 000: 100,101,111 -> 7,6,5
    do_reset();
    drive(0, 1'b1, 1'b0); expect_all("down0", 0, 1, 0, 0, 0, 0, 0);
    drive(4, 1'b1, 1'b0); expect_all("down1", 7, 1, 2, 0, 1, 0, 1);
    drive(5, 1'b1, 1'b0); expect_all("down2", 6, 1, 2, 0, 1, 0, 1);
    drive(7, 1'b1, 1'b0); expect_all("down3", 5, 1, 2, 0, 1, 0, 1);

    // Illegal jump 1 -> 3, decode in ERR, then Resync
    do_reset();
    drive(1, 1'b1, 1'b0); expect_all("ill0", 1, 1, 0, 0, 0, 0, 0);
    drive(2, 1'b1, 1'b0); expect_all("ill1", 3, 1, 3, 0, 0, 1, 0);
    drive(0, 1'b1, 1'b0); expect_all("ill2", 0, 1, 3, 0, 0, 1, 0);
    drive(0, 1'b0, 1'b1); expect_all("resync", 0, 0, 3, 0, 0, 0, 0);
    drive(3, 1'b1, 1'b0); expect_all("after_rs", 2, 1, 0, 0, 0, 0, 0);

    // Gaps and hold
    for (int i = 0; i < 3; i++) begin
      drive(6, 1'b0, 1'b0); expect_all("gap", 2, 0, 0, 0, 0, 0, 0);
    end
    drive(3, 1'b1, 1'b0); expect_all("hold", 2, 1, 0, 0, 0, 0, 0);

    // Resync with simultaneous En drops the sample
    drive(2, 1'b1, 1'b1); expect_all("rs_en", 2, 0, 0, 0, 0, 0, 0);

    // Async reset mid-stream, then a sample taken as reset deasserts
    do_reset();
    up_cycle();
    for (int i = 1; i <= 6; i++) drive(to_gray(i), 1'b1, 1'b0);
    expect_all("pre_areset", 6, 1, 1, 1, 0, 0, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    bus.En = 1'b1; bus.Gray_in = WIDTH'(6); bus.Resync = 1'b0;
    #1 expect_all("areset", 0, 0, 0, 0, 0, 0, 0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    expect_all("post_areset", 4, 1, 0, 0, 0, 0, 0);

    // Wrap counter saturation over 5 full up cycles
    do_reset();
    drive(0, 1'b1, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      up_cycle();
      chk("sat.wrap", 32'(bus.Wrap_cnt), (k < WMAX) ? k : WMAX);
      chk("sat.ovf",  32'(bus.Overflow), 1);
    end

    // Randomized traffic, checked by the model every cycle
    do_reset();
    cur = 0;
    for (int c = 0; c < 3000; c++) begin
      int r, roll;
      bit en, rs;
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
        cur = 0;
      end
      roll = $urandom_range(0, 99);
      rs = (roll < 4);
      en = (roll < 80);
      r = $urandom_range(0, 9);
      if (r <= 3 || r == 9) cur = (cur + 1) % N;
      else if (r <= 6) cur = (cur + N - 1) % N;
      else if (r == 8) cur = $urandom_range(0, N - 1);
      drive(to_gray(cur), en, rs);
    end

    drive(0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete, got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
